// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit for the EX stage.
// Owns the architectural HI/LO registers and stalls the front of the
// pipeline while an operation is in flight.
// Optional feature: define MULDIV_DIV_EN to build the divide datapath;
// without it, divide requests complete immediately and leave HI/LO untouched.
module ex_muldiv (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        div_by_zero_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg;
  logic        sign_a_reg, sign_b_reg;
  // Multiply: |A| (added each cycle). Divide: |B| (the divisor).
  logic [31:0] opnd_reg;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: low half shifts dividend bits out and quotient bits in.
  logic [63:0] acc_reg;
  logic [31:0] hi_reg, lo_reg;
  logic        done_reg;

  logic        is_signed;
  logic [31:0] mag_a, mag_b;
  logic        bypass_req;
  logic [32:0] mul_sum;
  logic [63:0] prod_fix;
  logic [31:0] fix_hi, fix_lo;

`ifdef MULDIV_DIV_EN
  logic        op_div_reg;
  logic        dbz_reg;
  // Remainder is always below the divisor, so 32 bits hold it; the
  // 33-bit working remainder is formed by shifting in the next dividend bit.
  logic [31:0] rem_reg;
  logic [32:0] div_shift;
  logic [32:0] div_trial;
  logic        div_borrow;
`endif

  // Operand magnitudes and the requests that finish without iterating
  always_comb begin
    is_signed = ~op_i[0];
    mag_a     = (is_signed && rs_data_i[31]) ? -rs_data_i : rs_data_i;
    mag_b     = (is_signed && rt_data_i[31]) ? -rt_data_i : rt_data_i;
`ifdef MULDIV_DIV_EN
    bypass_req = start_i & op_i[1] & (rt_data_i == 32'd0);
`else
    bypass_req = start_i & op_i[1];
`endif
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_sum = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
`ifdef MULDIV_DIV_EN
    div_shift  = {rem_reg, acc_reg[31]};
    div_trial  = div_shift - {1'b0, opnd_reg};
    div_borrow = div_trial[32];
`endif
  end

  // Sign correction applied in FIX
  always_comb begin
    prod_fix = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
    fix_hi   = prod_fix[63:32];
    fix_lo   = prod_fix[31:0];
`ifdef MULDIV_DIV_EN
    if (op_div_reg) begin
      fix_lo = (sign_a_reg ^ sign_b_reg) ? -acc_reg[31:0] : acc_reg[31:0];
      fix_hi = sign_a_reg ? -rem_reg : rem_reg;
    end
`endif
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_i && !bypass_req) state_next = CALC;
      CALC:    if (cnt_reg == 5'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, HI/LO write-back and done pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg    <= 5'd0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      opnd_reg   <= 32'd0;
      acc_reg    <= 64'd0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      done_reg   <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_div_reg <= 1'b0;
      dbz_reg    <= 1'b0;
      rem_reg    <= 32'd0;
`endif
    end else begin
      done_reg <= 1'b0;
`ifdef MULDIV_DIV_EN
      dbz_reg  <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            if (bypass_req) begin
              done_reg <= 1'b1;
`ifdef MULDIV_DIV_EN
              dbz_reg  <= 1'b1;
`endif
            end else begin
              cnt_reg    <= 5'd0;
              sign_a_reg <= is_signed & rs_data_i[31];
              sign_b_reg <= is_signed & rt_data_i[31];
`ifdef MULDIV_DIV_EN
              op_div_reg <= op_i[1];
              rem_reg    <= 32'd0;
              if (op_i[1]) begin
                opnd_reg <= mag_b;
                acc_reg  <= {32'd0, mag_a};
              end else begin
                opnd_reg <= mag_a;
                acc_reg  <= {32'd0, mag_b};
              end
`else
              opnd_reg <= mag_a;
              acc_reg  <= {32'd0, mag_b};
`endif
            end
          end
        end
        CALC: begin
          cnt_reg <= cnt_reg + 5'd1;
`ifdef MULDIV_DIV_EN
          if (op_div_reg) begin
            acc_reg[31:0] <= {acc_reg[30:0], ~div_borrow};
            rem_reg       <= div_borrow ? div_shift[31:0] : div_trial[31:0];
          end else begin
            acc_reg <= {mul_sum, acc_reg[31:1]};
          end
`else
          acc_reg <= {mul_sum, acc_reg[31:1]};
`endif
        end
        FIX: begin
          hi_reg   <= fix_hi;
          lo_reg   <= fix_lo;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hi_o    = hi_reg;
  assign lo_o    = lo_reg;
  assign busy_o  = (state_reg != IDLE);
  assign stall_o = busy_o | (start_i & (state_reg == IDLE) & ~bypass_req);
  assign done_o  = done_reg;
`ifdef MULDIV_DIV_EN
  assign div_by_zero_o = dbz_reg;
`else
  assign div_by_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv with hand-computed HI/LO results.
module tb_ex_muldiv;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] rs_data_i = 32'd0;
  logic [31:0] rt_data_i = 32'd0;
  logic [31:0] hi_o, lo_o;
  logic        busy_o, stall_o, done_o, div_by_zero_o;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  ex_muldiv dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .stall_o(stall_o),
    .done_o(done_o), .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Present a request for one cycle; returns just after the accepting edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic exp_stall, input string tag);
    start_i   = 1'b1;
    op_i      = op;
    rs_data_i = a;
    rt_data_i = b;
    #1;
    check({tag, ".stall_start"}, {31'd0, stall_o}, {31'd0, exp_stall});
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // Wait for done_o (bounded); checks latency, stall length and HI/LO.
  task automatic wait_done(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    int sc;
    n  = 1;
    sc = 1;
    while (!done_o && n < 100) begin
      if (stall_o) sc++;
      @(posedge clk_i); #1;
      n++;
    end
    check({tag, ".latency"}, n, 34);
    check({tag, ".stall_cycles"}, sc, 34);
    check({tag, ".hi"}, hi_o, exp_hi);
    check({tag, ".lo"}, lo_o, exp_lo);
  endtask

  // A request that must finish on the next edge without iterating.
  task automatic bypass_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic exp_dbz,
                           input logic [31:0] prev_hi, input logic [31:0] prev_lo);
    start_op(op, a, b, 1'b0, tag);
    check({tag, ".done"}, {31'd0, done_o}, 32'd1);
    check({tag, ".dbz"}, {31'd0, div_by_zero_o}, {31'd0, exp_dbz});
    check({tag, ".busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, ".hi_kept"}, hi_o, prev_hi);
    check({tag, ".lo_kept"}, lo_o, prev_lo);
    @(posedge clk_i); #1;
    check({tag, ".done_pulse"}, {31'd0, done_o}, 32'd0);
    check({tag, ".dbz_pulse"}, {31'd0, div_by_zero_o}, 32'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    #12;
    check("reset.hi", hi_o, 32'd0);
    check("reset.lo", lo_o, 32'd0);
    check("reset.busy", {31'd0, busy_o}, 32'd0);
    check("reset.stall", {31'd0, stall_o}, 32'd0);
    check("reset.done", {31'd0, done_o}, 32'd0);
    check("reset.dbz", {31'd0, div_by_zero_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // -2 * 3 = -6
    start_op(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b1, "mult_neg");
    wait_done("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFFA);
    check("mult_neg.stall_done", {31'd0, stall_o}, 32'd0);
    @(posedge clk_i); #1;
    check("mult_neg.done_pulse", {31'd0, done_o}, 32'd0);

    // (2^32-1)^2
    start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "multu_max");
    wait_done("multu_max", 32'hFFFFFFFE, 32'h00000001);
    @(posedge clk_i); #1;

    // -1 * -1 = 1
    start_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "mult_negneg");
    wait_done("mult_negneg", 32'h00000000, 32'h00000001);
    @(posedge clk_i); #1;

`ifdef MULDIV_DIV_EN
    start_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, "div_neg");
    wait_done("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    @(posedge clk_i); #1;
    start_op(OP_DIVU, 32'd100, 32'd7, 1'b1, "divu");
    wait_done("divu", 32'd2, 32'd14);
    @(posedge clk_i); #1;
    bypass_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 1'b1, 32'd2, 32'd14);
    start_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, "div_wrap");
    wait_done("div_wrap", 32'h00000000, 32'h80000000);
    check("div_wrap.dbz", {31'd0, div_by_zero_o}, 32'd0);
    @(posedge clk_i); #1;
`else
    bypass_op("div_off", OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 32'd0, 32'd1);
    bypass_op("divu_off", OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd0, 32'd1);
    bypass_op("divu_zero_off", OP_DIVU, 32'd5, 32'd0, 1'b0, 32'd0, 32'd1);
`endif

    // start held through CALC with new operands: ignored until the done cycle
    start_op(OP_MULTU, 32'h00010000, 32'h00010000, 1'b1, "held_first");
    start_i   = 1'b1;
    op_i      = OP_MULTU;
    rs_data_i = 32'd3;
    rt_data_i = 32'd5;
    wait_done("held_first", 32'd1, 32'd0);
    check("held_second.stall_start", {31'd0, stall_o}, 32'd1);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done("held_second", 32'd0, 32'd15);
    @(posedge clk_i); #1;

    // reset in the middle of CALC
    start_op(OP_MULT, 32'd1000, 32'd1000, 1'b1, "rst_mid");
    repeat (10) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_mid.hi", hi_o, 32'd0);
    check("rst_mid.lo", lo_o, 32'd0);
    check("rst_mid.busy", {31'd0, busy_o}, 32'd0);
    check("rst_mid.stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(posedge clk_i); #1;
        if (done_o) seen++;
      end
      check("rst_mid.no_done", seen, 0);
    end
    start_op(OP_MULT, 32'd6, 32'd7, 1'b1, "mult_6x7");
    wait_done("mult_6x7", 32'd0, 32'd42);
    @(posedge clk_i); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
